// File: rtl/apb_usrt_pkg.sv
// Shared constants and state encoding for the APB command/response master.
package apb_usrt_pkg;

  localparam int unsigned AddrWDefault   = 33;
  localparam int unsigned DataWDefault   = 8;
  localparam int unsigned TimeoutDefault = 255;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/apb_usrt_master_if.sv
// Command, response, APB and statistics signals of apb_usrt_master as one bundle.
interface apb_usrt_master_if
  import apb_usrt_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] pAddr;
  logic              pWrite;
  logic              pSelect;
  logic              pEnable;
  logic [DATA_W-1:0] pWData;
  logic [DATA_W-1:0] pRData;
  logic              pReady;
  logic              pSlvErr;
  logic [15:0]       xfer_count;
  logic [7:0]        err_count;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pRData, pReady, pSlvErr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output pAddr, pWrite, pSelect, pEnable, pWData, xfer_count, err_count
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pRData, pReady, pSlvErr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  pAddr, pWrite, pSelect, pEnable, pWData, xfer_count, err_count
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts consecutive not-ready ACCESS cycles; expired_o flags the TIMEOUT-th one.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [15:0] LastCnt = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Fires while the wait that would bring the count up to TIMEOUT is happening.
  assign expired_o = count_i && (cnt_q == LastCnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_usrt_master.sv
// Single-outstanding command/response to APB master with wait timeout and statistics.
module apb_usrt_master
  import apb_usrt_pkg::*;
#(
  parameter int unsigned ADDR_W  = AddrWDefault,
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input logic               pClk,
  input logic               pRst,
  apb_usrt_master_if.master bus
);

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0] p_addr_q, p_addr_d;
  logic              p_write_q, p_write_d;
  logic              p_select_q, p_select_d;
  logic              p_enable_q, p_enable_d;
  logic [DATA_W-1:0] p_wdata_q, p_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [15:0]       xfer_count_q, xfer_count_d;
  logic [7:0]        err_count_q, err_count_d;

  logic timer_clear, timer_count, timer_expired, end_xfer;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (pClk),
    .rst_i     (pRst),
    .clear_i   (timer_clear),
    .count_i   (timer_count),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    p_addr_d      = p_addr_q;
    p_write_d     = p_write_q;
    p_select_d    = p_select_q;
    p_enable_d    = p_enable_q;
    p_wdata_d     = p_wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    xfer_count_d  = xfer_count_q;
    err_count_d   = err_count_q;
    timer_clear   = 1'b0;
    timer_count   = 1'b0;
    end_xfer      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // cmd_ready_q is always 1 here, so cmd_valid alone is the handshake.
        if (bus.cmd_valid) begin
          cmd_ready_d = 1'b0;
          p_select_d  = 1'b1;
          p_addr_d    = bus.cmd_addr;
          p_write_d   = bus.cmd_write;
          p_wdata_d   = bus.cmd_write ? bus.cmd_wdata : '0;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        p_enable_d  = 1'b1;
        timer_clear = 1'b1;
        state_d     = StAccess;
      end
      StAccess: begin
        // pReady wins over the timer on the cycle the limit is reached.
        if (bus.pReady) begin
          rsp_rdata_d   = p_write_q ? '0 : bus.pRData;
          rsp_err_d     = bus.pSlvErr;
          rsp_timeout_d = 1'b0;
          end_xfer      = 1'b1;
        end else begin
          timer_count = 1'b1;
          if (timer_expired) begin
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            end_xfer      = 1'b1;
          end
        end
        if (end_xfer) begin
          rsp_valid_d = 1'b1;
          p_select_d  = 1'b0;
          p_enable_d  = 1'b0;
          p_addr_d    = '0;
          p_write_d   = 1'b0;
          p_wdata_d   = '0;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          cmd_ready_d   = 1'b1;
          xfer_count_d  = xfer_count_q + 16'd1;
          if (rsp_err_q) begin
            err_count_d = sat_inc8(err_count_q);
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pClk) begin
    if (pRst) begin
      state_q       <= StIdle;
      cmd_ready_q   <= 1'b1;
      p_addr_q      <= '0;
      p_write_q     <= 1'b0;
      p_select_q    <= 1'b0;
      p_enable_q    <= 1'b0;
      p_wdata_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      xfer_count_q  <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      p_addr_q      <= p_addr_d;
      p_write_q     <= p_write_d;
      p_select_q    <= p_select_d;
      p_enable_q    <= p_enable_d;
      p_wdata_q     <= p_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      xfer_count_q  <= xfer_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.pAddr       = p_addr_q;
  assign bus.pWrite      = p_write_q;
  assign bus.pSelect     = p_select_q;
  assign bus.pEnable     = p_enable_q;
  assign bus.pWData      = p_wdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.xfer_count  = xfer_count_q;
  assign bus.err_count   = err_count_q;

endmodule
